fifo_wr_adapter: RTL and testbench

FIFO_WR_ADAPTER -- requirements
Module: fifo_wr_adapter

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/fifo_skid2.sv | 84 ++++++++
 rtl/fifo_wr_adapter.sv | 89 ++++++++
 tb/tb_fifo_wr_adapter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side logic.
//   CntWidth     - width of the saturating statistics counters
//   skid_state_e - occupancy of the 2-entry skid buffer
//   gray_to_bin  - Gray-to-binary conversion, zero-extended to 32 bits
//   sat_inc      - saturating increment for CntWidth-wide counters
package fifo_pkg;

    localparam int unsigned CntWidth = 32;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } skid_state_e;

    // Narrower pointers are zero-extended by the caller; zero upper bits convert to zero.
    function automatic logic [31:0] gray_to_bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (&v) ? v : v + CntWidth'(1);
    endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry skid buffer in front of the FIFO write port.
// Ports:
//   wclk, wrst      - clock, synchronous active-high reset
//   s_valid, s_data - producer word
//   s_ready         - registered; low only while both entries are full
//   wfull           - FIFO full flag
//   winc, wdata     - write request and oldest buffered word
//   pop             - a word left the buffer this cycle (winc & ~wfull)
module fifo_skid2
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = 8
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             s_valid,
    input  logic [DSIZE-1:0] s_data,
    output logic             s_ready,
    input  logic             wfull,
    output logic             winc,
    output logic [DSIZE-1:0] wdata,
    output logic             pop
);

    skid_state_e      state_q, state_d;
    logic             s_ready_q;
    logic [DSIZE-1:0] buf0_q, buf0_d;  // oldest word, drives wdata
    logic [DSIZE-1:0] buf1_q, buf1_d;
    logic             push;

    always_comb begin
        state_d = state_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        push    = s_valid & s_ready_q;
        // Suppress the write in a reset cycle so buffered words are discarded, not written.
        winc    = (state_q != StEmpty) & ~wrst;
        pop     = winc & ~wfull;

        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    buf0_d  = s_data;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (push && pop) begin
                    buf0_d = s_data;
                end else if (push) begin
                    buf1_d  = s_data;
                    state_d = StTwo;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (pop) begin
                    buf0_d  = buf1_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q   <= StEmpty;
            s_ready_q <= 1'b1;
            buf0_q    <= '0;
            buf1_q    <= '0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= (state_d != StTwo);
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
        end
    end

    assign s_ready = s_ready_q;
    assign wdata   = buf0_q;

endmodule

// File: rtl/fifo_wr_adapter.sv
// Write-side adapter: valid/ready producer -> FIFO write port, with occupancy
// estimate and statistics.
// Ports:
//   wclk, wrst              - clock, synchronous active-high reset (assert with the
//                             write-pointer stage reset so wbcnt stays aligned)
//   s_valid, s_data, s_ready - producer handshake
//   wfull                   - FIFO full flag
//   wq2_rptr                - Gray read pointer synchronized into wclk
//   winc, wdata             - FIFO write request and data
//   wlevel, walmost_full    - registered occupancy estimate and threshold flag
//   wr_words, stall_cycles  - saturating statistics counters
module fifo_wr_adapter
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE        = 8,
    parameter int unsigned ADDRSIZE     = 8,
    parameter int unsigned AFULL_THRESH = 2**ADDRSIZE - 4
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                s_valid,
    input  logic [DSIZE-1:0]    s_data,
    output logic                s_ready,
    input  logic                wfull,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic                winc,
    output logic [DSIZE-1:0]    wdata,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full,
    output logic [CntWidth-1:0] wr_words,
    output logic [CntWidth-1:0] stall_cycles
);

    localparam int unsigned PtrW = ADDRSIZE + 1;
    // A threshold beyond the FIFO depth can never be legitimately reached.
    localparam bit AfullEn = (AFULL_THRESH <= 2**ADDRSIZE);

    logic                pop;
    logic [PtrW-1:0]     wbcnt_q;
    logic [PtrW-1:0]     rbin;
    logic [PtrW-1:0]     level;
    logic [PtrW-1:0]     wlevel_q;
    logic                walmost_full_q;
    logic [CntWidth-1:0] wr_words_q;
    logic [CntWidth-1:0] stall_cycles_q;

    fifo_skid2 #(
        .DSIZE(DSIZE)
    ) u_skid (
        .wclk   (wclk),
        .wrst   (wrst),
        .s_valid(s_valid),
        .s_data (s_data),
        .s_ready(s_ready),
        .wfull  (wfull),
        .winc   (winc),
        .wdata  (wdata),
        .pop    (pop)
    );

    assign rbin  = PtrW'(gray_to_bin(32'(wq2_rptr)));
    assign level = wbcnt_q - rbin;  // modulo 2**PtrW by width

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbcnt_q        <= '0;
            wlevel_q       <= '0;
            walmost_full_q <= 1'b0;
            wr_words_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (pop) begin
                wbcnt_q    <= wbcnt_q + PtrW'(1);
                wr_words_q <= sat_inc(wr_words_q);
            end
            if (winc && wfull) begin
                stall_cycles_q <= sat_inc(stall_cycles_q);
            end
            wlevel_q       <= level;
            walmost_full_q <= AfullEn && (32'(level) >= AFULL_THRESH);
        end
    end

    assign wlevel       = wlevel_q;
    assign walmost_full = walmost_full_q;
    assign wr_words     = wr_words_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_fifo_wr_adapter.sv
// Scoreboard bench for fifo_wr_adapter (DSIZE=8, ADDRSIZE=4, AFULL_THRESH=12).
// Inputs change just after the falling edge; an acceptor process queues every
// handshaken word and a monitor pops and compares on every FIFO write.
module tb_fifo_wr_adapter;

    logic        wclk = 1'b0;
    logic        wrst = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic        wfull = 1'b0;
    logic [4:0]  wq2_rptr = '0;
    logic        winc;
    logic [7:0]  wdata;
    logic [4:0]  wlevel;
    logic        walmost_full;
    logic [31:0] wr_words;
    logic [31:0] stall_cycles;

    int         n_tests = 0;
    int         n_fail = 0;
    int         pop_count = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_word;

    fifo_wr_adapter #(
        .DSIZE       (8),
        .ADDRSIZE    (4),
        .AFULL_THRESH(12)
    ) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .wfull       (wfull),
        .wq2_rptr    (wq2_rptr),
        .winc        (winc),
        .wdata       (wdata),
        .wlevel      (wlevel),
        .walmost_full(walmost_full),
        .wr_words    (wr_words),
        .stall_cycles(stall_cycles)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Acceptor: a word handshaken at the coming rising edge is expected on wdata later.
    always @(negedge wclk) begin
        #1;
        if (!wrst && s_valid && s_ready) exp_q.push_back(s_data);
    end

    // Monitor: every FIFO write must carry the oldest outstanding word.
    always @(negedge wclk) begin
        #2;
        if (winc && !wfull) begin
            pop_count++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got wdata %0h, expected no write", wdata);
            end else begin
                exp_word = exp_q.pop_front();
                check("wdata_order", {24'h0, wdata}, {24'h0, exp_word});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge wclk);
    endtask

    task automatic do_reset();
        wrst    = 1'b1;
        s_valid = 1'b0;
        wfull   = 1'b0;
        exp_q.delete();
        step(2);
        wrst      = 1'b0;
        pop_count = 0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_winc"}, {31'h0, winc}, 32'h0);
        check({tag, "_s_ready"}, {31'h0, s_ready}, 32'h1);
        check({tag, "_wdata"}, {24'h0, wdata}, 32'h0);
        check({tag, "_wlevel"}, {27'h0, wlevel}, 32'h0);
        check({tag, "_afull"}, {31'h0, walmost_full}, 32'h0);
        check({tag, "_wr_words"}, wr_words, 32'h0);
        check({tag, "_stall"}, stall_cycles, 32'h0);
    endtask

    // Present one word and hold it until accepted (bounded).
    task automatic send(input logic [7:0] d);
        bit ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            ok = s_ready;
            @(negedge wclk);
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got s_ready 0 for 50 cycles, expected 1");
        end
        s_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        @(negedge wclk);
        do_reset();
        #3;
        check_cleared("reset");
        @(negedge wclk);

        // Streaming: one word per cycle, first write one cycle after first accept.
        s_valid = 1'b1;
        s_data  = 8'h01;
        #3;
        check("stream_first_winc", {31'h0, winc}, 32'h0);
        @(negedge wclk);
        for (int i = 2; i <= 16; i++) begin
            s_data = 8'(i);
            #3;
            check("stream_winc", {31'h0, winc}, 32'h1);
            check("stream_ready", {31'h0, s_ready}, 32'h1);
            @(negedge wclk);
        end
        s_valid = 1'b0;
        #3;
        check("stream_last_winc", {31'h0, winc}, 32'h1);
        @(negedge wclk);
        #3;
        check("stream_idle_winc", {31'h0, winc}, 32'h0);
        @(negedge wclk);
        step(1);
        check("stream_wr_words", wr_words, 32'd16);
        check("stream_drained", exp_q.size(), 32'd0);

        // Backpressure with both entries full.
        do_reset();
        s_valid = 1'b1;
        s_data  = 8'hA1;
        @(negedge wclk);
        s_data = 8'hB2;
        wfull  = 1'b1;
        @(negedge wclk);
        s_data = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            #3;
            check("bp_s_ready", {31'h0, s_ready}, 32'h0);
            check("bp_wdata", {24'h0, wdata}, 32'hA1);
            check("bp_winc", {31'h0, winc}, 32'h1);
            @(negedge wclk);
        end
        wfull = 1'b0;
        #3;
        check("bp_stall", stall_cycles, 32'd5);
        @(negedge wclk);
        @(negedge wclk);
        s_valid = 1'b0;
        step(4);
        check("bp_drained", exp_q.size(), 32'd0);
        check("bp_wr_words", wr_words, 32'd3);
        check("bp_stall_final", stall_cycles, 32'd5);

        // Level and almost-full threshold.
        do_reset();
        for (int i = 0; i < 14; i++) send(8'(8'h20 + i));
        step(3);
        check("lvl14_wlevel", {27'h0, wlevel}, 32'd14);
        check("lvl14_afull", {31'h0, walmost_full}, 32'h1);
        wq2_rptr = 5'b00110;
        step(2);
        check("lvl10_wlevel", {27'h0, wlevel}, 32'd10);
        check("lvl10_afull", {31'h0, walmost_full}, 32'h0);
        wq2_rptr = 5'b00000;

        // Write-count wrap.
        do_reset();
        for (int i = 0; i < 40; i++) send(8'(8'h40 + i));
        step(3);
        check("wrap_wlevel", {27'h0, wlevel}, 32'd8);
        check("wrap_afull", {31'h0, walmost_full}, 32'h0);
        check("wrap_wr_words", wr_words, 32'd40);

        // Reset while two words are buffered.
        do_reset();
        s_valid = 1'b1;
        s_data  = 8'h5A;
        @(negedge wclk);
        s_data = 8'hA5;
        wfull  = 1'b1;
        @(negedge wclk);
        s_valid = 1'b0;
        #3;
        check("pre_rst_s_ready", {31'h0, s_ready}, 32'h0);
        @(negedge wclk);
        wrst  = 1'b1;
        wfull = 1'b0;
        exp_q.delete();
        #3;
        check("rst_cycle_winc", {31'h0, winc}, 32'h0);
        @(negedge wclk);
        wrst      = 1'b0;
        pop_count = 0;
        #3;
        check_cleared("midrst");
        @(negedge wclk);
        step(5);
        check("midrst_no_writes", pop_count, 32'd0);

        // Random valid and full.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom);
            wfull   = ($urandom_range(0, 3) == 0);
            @(negedge wclk);
        end
        s_valid = 1'b0;
        wfull   = 1'b0;
        step(5);
        check("rand_drained", exp_q.size(), 32'd0);
        check("rand_wr_words", wr_words, pop_count);
        check("rand_wlevel", {27'h0, wlevel}, pop_count % 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
